// File: rtl/parity_ser_tx.sv
// Serial parity transmitter: sends a parallel word MSB-first and then one parity bit.
// The parity bit is accumulated as the data bits leave the shift register.
module parity_ser_tx #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              sel,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              dout_last
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              acc_reg, acc_next;
  logic              accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      acc_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
    end
  end

  assign accept = din_valid && din_ready;

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
          shift_next = din;
          cnt_next   = CNT_LOAD;
          acc_next   = ~sel;
        end
      end
      SHIFT: begin
        shift_next = {shift_reg[DATA_W-2:0], 1'b0};
        acc_next   = acc_reg ^ shift_reg[DATA_W-1];
        // Reaching zero ends the data phase before the counter could wrap.
        if (cnt_reg == '0) begin
          state_next = PARITY;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      PARITY: begin
        if (accept) begin
          state_next = SHIFT;
          shift_next = din;
          cnt_next   = CNT_LOAD;
          acc_next   = ~sel;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore outputs decoded purely from registered state, so reset clears them at once.
  always_comb begin
    din_ready  = (state_reg != SHIFT);
    dout_valid = (state_reg == SHIFT) || (state_reg == PARITY);
    dout_last  = (state_reg == PARITY);
    dout       = 1'b0;
    if (state_reg == SHIFT) begin
      dout = shift_reg[DATA_W-1];
    end else if (state_reg == PARITY) begin
      dout = acc_reg;
    end
  end

endmodule

// File: tb/tb_parity_ser_tx.sv
// Self-checking bench for parity_ser_tx: directed and random frames against a
// word-level reference (bit order and popcount parity).
module tb_parity_ser_tx;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         sel = 1'b0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic         dout;
  logic         dout_valid;
  logic         dout_last;

  int n_checks = 0;
  int n_fail   = 0;

  parity_ser_tx #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .sel        (sel),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last)
  );

  always #5 clk = ~clk;

  // Receiver-side definition: sel=1 -> XOR of bits, sel=0 -> its inverse.
  function automatic logic ref_parity(input logic [W-1:0] w, input logic s);
    int ones;
    ones = $countones(w);
    return s ? logic'(ones % 2) : logic'(1 - (ones % 2));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, dout_valid, 1'b0);
    chk({tag, "_dout"},  dout,       1'b0);
    chk({tag, "_last"},  dout_last,  1'b0);
    chk({tag, "_ready"}, din_ready,  1'b1);
  endtask

  // Called at a negedge; returns at the negedge of the first data cycle.
  task automatic start_word(input logic [W-1:0] w, input logic s);
    int k;
    din = w;
    sel = s;
    din_valid = 1'b1;
    k = 0;
    while (din_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_accept", din_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // Checks a whole frame starting at its first data cycle; offers the next word in the parity cycle.
  task automatic check_frame(input logic [W-1:0] w, input logic s, input bit noise,
                             input logic nxt_valid, input logic [W-1:0] nxt_w, input logic nxt_s);
    for (int i = W - 1; i >= 0; i--) begin
      chk("shift_valid", dout_valid, 1'b1);
      chk("shift_bit",   dout,       w[i]);
      chk("shift_ready", din_ready,  1'b0);
      chk("shift_last",  dout_last,  1'b0);
      if (noise) begin
        din       = $urandom;
        sel       = 1'($urandom);
        din_valid = 1'($urandom);
      end
      @(negedge clk);
    end
    chk("par_valid", dout_valid, 1'b1);
    chk("par_last",  dout_last,  1'b1);
    chk("par_bit",   dout,       ref_parity(w, s));
    chk("par_ready", din_ready,  1'b1);
    din_valid = nxt_valid;
    din       = nxt_w;
    sel       = nxt_s;
    @(negedge clk);
    if (!nxt_valid) chk_idle("post_frame");
  endtask

  initial begin
    logic [W-1:0] w, w2;
    logic         s, s2;

    // Reset state
    #1;
    chk_idle("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle("after_reset");

    // Single frame, sel=1
    start_word(32'hA5A5_0001, 1'b1);
    check_frame(32'hA5A5_0001, 1'b1, 1'b0, 1'b0, '0, 1'b0);

    // Odd/even modes on the same word
    start_word(32'h0000_0003, 1'b0);
    check_frame(32'h0000_0003, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    start_word(32'h0000_0003, 1'b1);
    check_frame(32'h0000_0003, 1'b1, 1'b0, 1'b0, '0, 1'b0);

    // Back-to-back with din_valid held high: 66 consecutive valid cycles
    start_word(32'hFFFF_FFFF, 1'b1);
    din_valid = 1'b1;
    din = 32'h0000_0000;
    check_frame(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
    check_frame(32'h0000_0000, 1'b1, 1'b0, 1'b0, '0, 1'b0);

    // Reset at bit 10 of a frame
    w = $urandom;
    start_word(w, 1'b1);
    for (int i = W - 1; i > W - 11; i--) begin
      chk("pre_rst_bit", dout, w[i]);
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    @(posedge clk);
    @(negedge clk);
    chk_idle("held_reset");
    rst_n = 1'b1;
    start_word(32'h8000_0000, 1'b0);
    check_frame(32'h8000_0000, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    // sel/din/din_valid noise during SHIFT must not affect the frame in flight
    w = $urandom;
    start_word(w, 1'b0);
    check_frame(w, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    w = $urandom;
    start_word(w, 1'b1);
    check_frame(w, 1'b1, 1'b1, 1'b0, '0, 1'b0);

    // Random frames, randomly chained back-to-back
    w = $urandom;
    s = 1'($urandom);
    start_word(w, s);
    for (int f = 0; f < 16; f++) begin
      bit chain;
      chain = 1'($urandom);
      w2 = $urandom;
      s2 = 1'($urandom);
      check_frame(w, s, 1'($urandom), chain, w2, s2);
      if (!chain) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        start_word(w2, s2);
      end
      w = w2;
      s = s2;
    end
    check_frame(w, s, 1'b0, 1'b0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
